// File: rtl/id_ex_operand_stage.sv
// ID/EX register for the MIPS150 datapath.
// Forms ALU operands with MEM/WB forwarding and load-use bubbles.
module id_ex_operand_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [15:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_aluop,
  input  logic        id_use_imm,
  input  logic        id_imm_zext,
  input  logic        id_shift_const,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [31:0] mem_result,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic [31:0] wb_data,
  input  logic        flush,
  input  logic        ex_stall,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  output logic [4:0]  ALUop,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic [4:0]  ex_rd,
  output logic        stall_id
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic        use_imm;
    logic        imm_zext;
    logic        shift_const;
    logic        reg_write;
    logic        mem_read;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t id_d;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic [31:0] imm_ext;
  logic        lu;

  assign id_d = '{
    valid:       id_valid,
    rs_data:     id_rs_data,
    rt_data:     id_rt_data,
    rs:          id_rs,
    rt:          id_rt,
    rd:          id_rd,
    imm:         id_imm,
    shamt:       id_shamt,
    aluop:       id_aluop,
    use_imm:     id_use_imm,
    imm_zext:    id_imm_zext,
    shift_const: id_shift_const,
    reg_write:   id_reg_write,
    mem_read:    id_mem_read
  };

  // Forward the youngest in-flight writer; $0 is never forwarded.
  always_comb begin
    fwd_rs = ex_q.rs_data;
    fwd_rt = ex_q.rt_data;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_q.rs)
      fwd_rs = mem_result;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_q.rs)
      fwd_rs = wb_data;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_q.rt)
      fwd_rt = mem_result;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_q.rt)
      fwd_rt = wb_data;
  end

  // Load in EX whose result the ID instruction needs next cycle.
  always_comb begin
    lu = 1'b0;
    if (ex_q.valid && ex_q.mem_read && id_valid && ex_q.rd != 5'd0)
      lu = (id_uses_rs && ex_q.rd == id_rs) ||
           (id_uses_rt && ex_q.rd == id_rt);
  end

  assign stall_id = ex_stall | (lu & ~flush);

  // Slot update: flush, then hold, then bubble, then advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (ex_stall) begin
      ex_q.rs_data <= fwd_rs;
      ex_q.rt_data <= fwd_rt;
    end else if (lu) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_d;
    end
  end

  assign imm_ext = ex_q.imm_zext ? {16'b0, ex_q.imm}
                                 : {{16{ex_q.imm[15]}}, ex_q.imm};

  assign operand1 = ex_q.shift_const ? {27'b0, ex_q.shamt} : fwd_rs;
  assign operand2 = ex_q.use_imm ? imm_ext : fwd_rt;

  assign ALUop        = ex_q.aluop;
  assign ex_valid     = ex_q.valid;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_rd        = ex_q.rd;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage.
// Hand-computed vectors checked with immediate assertions.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm;
  logic [4:0]  id_shamt, id_aluop;
  logic        id_use_imm, id_imm_zext, id_shift_const;
  logic        id_uses_rs, id_uses_rt;
  logic        id_reg_write, id_mem_read;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [31:0] mem_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        flush, ex_stall;
  logic [31:0] operand1, operand2;
  logic [4:0]  ALUop;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        stall_id;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_aluop(id_aluop),
    .id_use_imm(id_use_imm), .id_imm_zext(id_imm_zext),
    .id_shift_const(id_shift_const),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .flush(flush), .ex_stall(ex_stall),
    .operand1(operand1), .operand2(operand2), .ALUop(ALUop),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .stall_id(stall_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_id();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_imm = 0; id_shamt = 0; id_aluop = 0;
    id_use_imm = 0; id_imm_zext = 0; id_shift_const = 0;
    id_uses_rs = 0; id_uses_rt = 0;
    id_reg_write = 0; id_mem_read = 0;
  endtask

  task automatic no_fwd();
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_data = 0;
  endtask

  task automatic load_lw();
    idle_id();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1;
    id_rd = 8; id_rs = 2; id_uses_rs = 1;
    id_rs_data = 32'd100; id_use_imm = 1; id_imm = 16'd4;
    id_aluop = 5'd2;
  endtask

  task automatic load_add();
    idle_id();
    id_valid = 1; id_reg_write = 1; id_rd = 10;
    id_rs = 8; id_rt = 3; id_uses_rs = 1; id_uses_rt = 1;
    id_rs_data = 32'hDEAD; id_rt_data = 32'd5;
    id_aluop = 5'd1;
  endtask

  initial begin
    rst = 1; flush = 0; ex_stall = 0;
    idle_id();
    no_fwd();
    #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_aluop", ALUop, 0);
    chk("rst_op1", operand1, 0);
    chk("rst_op2", operand2, 0);
    chk("rst_stall", stall_id, 0);
    ex_stall = 1;
    #1;
    chk("rst_stall_follow", stall_id, 1);
    ex_stall = 0;
    tick();
    rst = 0;

    // sign-extended immediate
    id_valid = 1; id_use_imm = 1; id_imm = 16'hFFFF;
    id_aluop = 5'd3; id_reg_write = 1; id_rd = 9;
    tick();
    chk("sext_valid", ex_valid, 1);
    chk("sext_op2", operand2, 32'hFFFFFFFF);
    chk("sext_aluop", ALUop, 3);
    chk("sext_rd", ex_rd, 9);
    chk("sext_rw", ex_reg_write, 1);

    // zero-extended immediate
    id_imm_zext = 1;
    tick();
    chk("zext_op2", operand2, 32'h0000FFFF);

    // constant shift
    id_use_imm = 0; id_imm_zext = 0; id_shift_const = 1;
    id_shamt = 3; id_rt_data = 1; id_rt = 7;
    tick();
    chk("shift_op1", operand1, 3);
    chk("shift_op2", operand2, 1);

    // forwarding priority on rs = 5
    id_shift_const = 0; id_shamt = 0;
    id_rs = 5; id_rs_data = 32'h99; id_uses_rs = 1;
    tick();
    chk("fwd_none", operand1, 32'h99);
    mem_reg_write = 1; mem_rd = 5; mem_result = 32'h11;
    wb_reg_write = 1; wb_rd = 5; wb_data = 32'h22;
    #1;
    chk("fwd_mem_first", operand1, 32'h11);
    mem_reg_write = 0;
    #1;
    chk("fwd_wb", operand1, 32'h22);
    id_rs = 0; id_rs_data = 32'h33; wb_rd = 0;
    tick();
    chk("fwd_r0_reg", operand1, 32'h33);
    mem_reg_write = 1; mem_rd = 0; mem_result = 32'h11;
    #1;
    chk("fwd_r0_never", operand1, 32'h33);
    no_fwd();

    // async reset between edges
    #2;
    chk("pre_rst_valid", ex_valid, 1);
    rst = 1;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_aluop", ALUop, 0);
    chk("arst_op1", operand1, 0);
    chk("arst_op2", operand2, 0);
    rst = 0;

    // load-use: lw $8 then add using $8
    load_lw();
    tick();
    chk("lw_in_ex", ex_mem_read, 1);
    load_add();
    #1;
    chk("lu_stall", stall_id, 1);
    tick();
    chk("bubble_valid", ex_valid, 0);
    chk("bubble_memrd", ex_mem_read, 0);
    chk("lu_stall_once", stall_id, 0);
    mem_rd = 8; mem_reg_write = 1; mem_result = 32'h1234;
    tick();
    chk("add_valid", ex_valid, 1);
    chk("add_rd", ex_rd, 10);
    chk("add_op1_mem", operand1, 32'h1234);
    chk("add_op2", operand2, 5);
    no_fwd();

    // stall for 3 cycles with WB match in the first only
    ex_stall = 1;
    wb_reg_write = 1; wb_rd = 8; wb_data = 32'h5555;
    id_aluop = 5'd7; id_rd = 12;
    #1;
    chk("stall_out", stall_id, 1);
    chk("stall_wb_c0", operand1, 32'h5555);
    tick();
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    #1;
    chk("stall_wb_c1", operand1, 32'h5555);
    tick();
    chk("stall_wb_c2", operand1, 32'h5555);
    chk("stall_hold_aluop", ALUop, 1);
    chk("stall_hold_rd", ex_rd, 10);
    chk("stall_hold_valid", ex_valid, 1);

    // flush wins over stall
    flush = 1;
    tick();
    chk("flush_stall_valid", ex_valid, 0);
    chk("flush_stall_rw", ex_reg_write, 0);
    flush = 0; ex_stall = 0;

    // flush together with load-use: ID advances
    load_lw();
    tick();
    load_add();
    flush = 1;
    #1;
    chk("flush_lu_nostall", stall_id, 0);
    tick();
    chk("flush_lu_valid", ex_valid, 0);
    flush = 0;
    tick();
    chk("after_flush_valid", ex_valid, 1);
    chk("after_flush_aluop", ALUop, 1);

    // reset during a load-use stall
    load_lw();
    tick();
    load_add();
    #1;
    chk("pre_rst_lu", stall_id, 1);
    rst = 1;
    #1;
    chk("rst_lu_stall", stall_id, 0);
    chk("rst_lu_valid", ex_valid, 0);
    rst = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline stage of the MIPS150 datapath, directly upstream of the 32-bit ALU. It registers decoded instruction fields and forms the ALU's `operand1`, `operand2` and `ALUop`. Forming the operands covers MEM/WB forwarding, immediate extension and shift-amount selection. It also detects load-use hazards, inserts bubbles, and honours flush and downstream-stall controls.

## Interface
Parameters: none; widths are fixed by the ISA.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: the ID slot holds a real instruction.
- `id_rs_data`, `id_rt_data` in 32 each: register-file read data.
- `id_rs`, `id_rt`, `id_rd` in 5 each: source and destination register indices.
- `id_imm` in 16: immediate. `id_shamt` in 5: shift amount. `id_aluop` in 5: ALU operation code.
- `id_use_imm`, `id_imm_zext`, `id_shift_const` in 1 each: operand-select controls.
- `id_uses_rs`, `id_uses_rt` in 1 each: the instruction reads that source register.
- `id_reg_write`, `id_mem_read` in 1 each: destination-write and load flags.
- `mem_rd` in 5, `mem_reg_write` in 1, `mem_result` in 32: EX/MEM forwarding source.
- `wb_rd` in 5, `wb_reg_write` in 1, `wb_data` in 32: MEM/WB forwarding source.
- `flush` in 1: squash the EX slot (branch taken or jump).
- `ex_stall` in 1: downstream is not accepting; hold the EX slot.
- `operand1`, `operand2` out 32 each: ALU operands (combinational from registered state).
- `ALUop` out 5: registered `id_aluop`.
- `ex_valid`, `ex_reg_write`, `ex_mem_read` out 1 each; `ex_rd` out 5.
- `stall_id` out 1: hold the PC and the IF/ID register.

## Operation
- Registered fields: valid, rs_data, rt_data, rs, rt, rd, imm, shamt, aluop, use_imm, imm_zext, shift_const, reg_write, mem_read.
- Load-use hazard (`lu`) is asserted when all of the following hold:
  - `ex_valid`, `ex_mem_read` and `id_valid` are 1;
  - `ex_rd` is non-zero;
  - either (`id_uses_rs` and `ex_rd == id_rs`) or (`id_uses_rt` and `ex_rd == id_rt`).
- `stall_id = ex_stall | (lu & ~flush)`, combinational.
- Update priority on each clock edge, highest first:
  1. `flush`: valid, reg_write and mem_read go to 0; all other fields clear to 0.
  2. `ex_stall`: every field holds, except that rs_data and rt_data reload from their forwarded values. A value forwarded from WB therefore survives after the writer retires.
  3. `lu`: insert a bubble (valid, reg_write and mem_read go to 0; other fields don't care). ID holds.
  4. Otherwise: load every field from the `id_*` inputs; valid takes `id_valid`.
- Forwarding, rs path (rt path is identical, with rt in place of rs). Select the first match:
  1. MEM: `mem_reg_write` and `mem_rd != 0` and `mem_rd == ex_rs` gives `mem_result`.
  2. WB: `wb_reg_write` and `wb_rd != 0` and `wb_rd == ex_rs` gives `wb_data`.
  3. Otherwise the registered rs_data.
- Register 0 is never forwarded.
- `operand1` = shift_const ? {27'b0, shamt} : fwd_rs. Variable shifts use rs as the amount.
- `operand2` = use_imm ? (imm_zext ? {16'b0, imm} : {{16{imm[15]}}, imm}) : fwd_rt.
- LUI is handled by driving use_imm; the ALU takes `operand2[15:0]`.
- When `ex_valid = 0`, `ALUop` and the operands still follow the registered state. Downstream ignores them because `ex_reg_write` and `ex_mem_read` are 0.

## Timing
- Reset (asynchronous) forces all registered fields to 0 immediately, without waiting for a clock edge:
  - `ex_valid`, `ex_reg_write`, `ex_mem_read` = 0; `ex_rd` = 0; `ALUop` = 0.
  - `operand1` and `operand2` = 0, unless forwarding matches; MEM/WB must also be in reset.
  - `stall_id` = `ex_stall`.
- Latency: one cycle from an ID input to its EX fields. Forwarding, operand formation and `stall_id` are zero-latency combinational.
- A load-use stall lasts exactly one cycle when `ex_stall = 0`. On the following cycle the load sits in MEM and is forwarded from `mem_result`.
- `flush` and `ex_stall` asserted together: flush wins and the slot empties.
- `flush` and `lu` asserted together: the slot empties and `stall_id` stays 0, so ID advances.
- Reset asserted mid-stall: the slot clears and the stall drops immediately.

## Test plan
- Async reset mid-operation: assert `rst` between clock edges -> `ex_valid`, `ALUop`, `operand1` and `operand2` all read 0 before the next edge.
- Immediates: `id_imm = 16'hFFFF` with `use_imm = 1`:
  - `imm_zext = 0` -> `operand2 = 32'hFFFFFFFF`;
  - `imm_zext = 1` -> `operand2 = 32'h0000FFFF`.
- Shift: `id_shift_const = 1`, `shamt = 3`, `rt_data = 32'h1` -> `operand1 = 3`, `operand2 = 1`.
- Forwarding priority, with `ex_rs = 5`:
  - `mem_rd = 5`, `mem_result = 32'h11` and `wb_rd = 5`, `wb_data = 32'h22` -> `operand1 = 32'h11`;
  - with `mem_reg_write = 0` -> `operand1 = 32'h22`;
  - with `ex_rs = 0` and `wb_rd = 0` -> registered data is used.
- Load-use: `lw $8` in EX, `add` in ID with `id_rs = 8`:
  - `stall_id = 1` for exactly one cycle and a bubble enters EX (`ex_valid = 0`);
  - next cycle the add is in EX and takes `operand1 = mem_result`.
- Stall/flush interplay:
  - `ex_stall` held 3 cycles while `wb_rd` matches for the first cycle only -> `operand1` keeps the WB value throughout;
  - `flush` and `ex_stall` together -> `ex_valid = 0` on the next edge.
